// File: rtl/fft_pkg.sv
// Shared constants, sample type and bit-reversal helper for the FFT output reorder path.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
// Contents: DATA_W/LOG2N/N constants, cplx_t {re, im}, rd_state_t read FSM encoding, bitrev().
package fft_pkg;

  localparam int DATA_W = 16;
  localparam int LOG2N  = 5;
  localparam int N      = 1 << LOG2N;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  // Mirror the address bits: the SDF pipeline emits bin bitrev(k) as its k-th sample.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame bank of the reorder buffer: 2^AW words, synchronous write, combinational read.
// Latency: a write is visible on rdat the cycle after we is sampled.
// Backpressure: none; the owner decides when to write and read.
// Ports: clk, we, waddr[AW], wdat[W] (write side); raddr[AW] -> rdat[W] (read side).
module fft_reorder_bank #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdat,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdat
);

  localparam int DEPTH = 1 << AW;

  // Contents are left unreset: every word is rewritten before its frame is marked full.
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdat;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdat = mem_q[raddr];

endmodule

// File: rtl/fft_reorder.sv
// Bit-reversal reorder of the 32-point SDF FFT output: bit-reversed input frames out in natural order.
// Latency: bin 0 is valid the cycle after the 32nd sample of a frame is written; 1 sample/cycle sustained.
// Backpressure: output holds while valid_o && !ready_i; input is never stalled, samples arriving into a full bank are dropped (sticky overflow_o).
// Ports: clk, rst; valid_i, data_in_r/i (input stream); valid_o, ready_i, data_out_r/i, index_o, sof_o (output); overflow_o.
module fft_reorder #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int LOG2N  = fft_pkg::LOG2N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_in_r,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_out_r,
  output logic [DATA_W-1:0] data_out_i,
  output logic [LOG2N-1:0]  index_o,
  output logic              sof_o,
  output logic              overflow_o
);

  import fft_pkg::*;

  localparam int               NW   = 2 * DATA_W;
  localparam logic [LOG2N-1:0] LAST = LOG2N'((1 << LOG2N) - 1);

  // Bank bookkeeping
  logic [1:0]       full_q, full_d;
  logic             wb_q, wb_d;
  logic             rb_q, rb_d;
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  rd_state_t        state_q, state_d;

  // Output register
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] dout_r_q, dout_r_d;
  logic [DATA_W-1:0] dout_i_q, dout_i_d;
  logic [LOG2N-1:0]  index_q, index_d;
  logic              sof_q, sof_d;
  logic              ovf_q, ovf_d;

  // Bank ports
  logic             wr_en;
  logic [1:0]       bank_we;
  logic [LOG2N-1:0] waddr;
  logic [NW-1:0]    wdat;
  logic [NW-1:0]    rdat0, rdat1, rdat;
  logic             can_adv;
  logic             load;

  assign wr_en   = valid_i && !full_q[wb_q];
  assign waddr   = bitrev(wcnt_q);
  assign wdat    = {data_in_r, data_in_i};
  assign bank_we = {wr_en && wb_q, wr_en && !wb_q};
  assign rdat    = rb_q ? rdat1 : rdat0;
  assign can_adv = !valid_q || ready_i;

  fft_reorder_bank #(.W(NW), .AW(LOG2N)) u_bank0 (
    .clk   (clk),
    .we    (bank_we[0]),
    .waddr (waddr),
    .wdat  (wdat),
    .raddr (rcnt_q),
    .rdat  (rdat0)
  );

  fft_reorder_bank #(.W(NW), .AW(LOG2N)) u_bank1 (
    .clk   (clk),
    .we    (bank_we[1]),
    .waddr (waddr),
    .wdat  (wdat),
    .raddr (rcnt_q),
    .rdat  (rdat1)
  );

  always_comb begin
    full_d   = full_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    wcnt_d   = wcnt_q;
    rcnt_d   = rcnt_q;
    state_d  = state_q;
    valid_d  = valid_q;
    dout_r_d = dout_r_q;
    dout_i_d = dout_i_q;
    index_d  = index_q;
    sof_d    = sof_q;
    ovf_d    = ovf_q;
    load     = 1'b0;

    // Write side. A write and a free can never hit the same bank in one cycle:
    // writing needs full[wb] clear while reading needs full[rb] set.
    if (wr_en) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == LAST) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end
    if (valid_i && full_q[wb_q]) begin
      ovf_d = 1'b1;
    end

    // Read side. rcnt is always 0 in IDLE (it wraps on the last load), so IDLE
    // can load entry 0 in the same cycle it notices a full bank; this removes
    // the bubble between frames and gives bin 0 one cycle after the last write.
    unique case (state_q)
      RD_IDLE: begin
        if (full_q[rb_q]) begin
          state_d = RD_STREAM;
          load    = can_adv;
        end
      end
      RD_STREAM: begin
        load = can_adv;
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase

    if (load) begin
      valid_d  = 1'b1;
      dout_r_d = rdat[NW-1:DATA_W];
      dout_i_d = rdat[DATA_W-1:0];
      index_d  = rcnt_q;
      sof_d    = (rcnt_q == '0);
      rcnt_d   = rcnt_q + 1'b1;
      state_d  = RD_STREAM;
      if (rcnt_q == LAST) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        state_d      = full_q[~rb_q] ? RD_STREAM : RD_IDLE;
      end
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= '0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      state_q  <= RD_IDLE;
      valid_q  <= 1'b0;
      dout_r_q <= '0;
      dout_i_q <= '0;
      index_q  <= '0;
      sof_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      full_q   <= full_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
      dout_r_q <= dout_r_d;
      dout_i_q <= dout_i_d;
      index_q  <= index_d;
      sof_q    <= sof_d;
      ovf_q    <= ovf_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_out_r = dout_r_q;
  assign data_out_i = dout_i_q;
  assign index_o    = index_q;
  assign sof_o      = sof_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder: scoreboard of natural-order bins, one task per scenario.
module tb_fft_reorder;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [15:0] data_in_r;
  logic [15:0] data_in_i;
  logic        ready_i;
  logic        valid_o;
  logic [15:0] data_out_r;
  logic [15:0] data_out_i;
  logic [4:0]  index_o;
  logic        sof_o;
  logic        overflow_o;

  fft_reorder dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i),
    .index_o    (index_o),
    .sof_o      (sof_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [4:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   xfer_cnt = 0;

  function automatic logic [4:0] brev5(input logic [4:0] a);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

  // Scoreboard: every accepted output transfer is popped and compared.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && valid_o && ready_i) begin
      xfer_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output idx=%0d re=%h im=%h (no output expected)", index_o, data_out_r, data_out_i);
      end else begin
        e = sb.pop_front();
        if ({data_out_r, data_out_i, index_o, sof_o} !== {e.re, e.im, e.idx, (e.idx == 5'd0)}) begin
          failures++;
          $display("FAIL output got re=%h im=%h idx=%0d sof=%b expected re=%h im=%h idx=%0d sof=%b",
                   data_out_r, data_out_i, index_o, sof_o, e.re, e.im, e.idx, (e.idx == 5'd0));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached (bench did not finish)");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] r, input logic [15:0] im);
    valid_i   = 1'b1;
    data_in_r = r;
    data_in_i = im;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  function automatic logic [15:0] sval(input int f, input int k);
    return 16'(f * 256 + k);
  endfunction

  task automatic push_frame(input int f);
    exp_t e;
    for (int j = 0; j < 32; j++) begin
      e.re  = sval(f, int'(brev5(5'(j))));
      e.im  = -sval(f, int'(brev5(5'(j))));
      e.idx = 5'(j);
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(input int f, input int gap_pct);
    for (int k = 0; k < 32; k++) begin
      while (int'($urandom_range(99)) < gap_pct) tick();
      put(sval(f, k), -sval(f, k));
    end
    push_frame(f);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout remaining=%0d required=0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_in_r = '0;
    data_in_i = '0;
    #1;
    repeat (2) tick();
    checks++;
    if ({valid_o, data_out_r, data_out_i, index_o, sof_o, overflow_o} !== 39'd0) begin
      failures++;
      $display("FAIL reset_state valid=%b re=%h im=%h idx=%0d sof=%b ovf=%b required all zero",
               valid_o, data_out_r, data_out_i, index_o, sof_o, overflow_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    ready_i = 1'b1;
    push_frame(0);
    for (int k = 0; k < 32; k++) begin
      put(sval(0, k), -sval(0, k));
    end
    // Last write just happened: bin 0 is loaded at the next edge.
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL latency_early valid_o=%b required 0", valid_o);
    end
    tick();
    checks++;
    if ({valid_o, index_o, sof_o, data_out_r, data_out_i} !== {1'b1, 5'd0, 1'b1, 16'd0, 16'd0}) begin
      failures++;
      $display("FAIL bin0 valid=%b idx=%0d sof=%b re=%h im=%h required 1/0/1/0/0",
               valid_o, index_o, sof_o, data_out_r, data_out_i);
    end
    tick();
    checks++;
    if ({index_o, data_out_r, data_out_i, sof_o} !== {5'd1, 16'd16, -16'd16, 1'b0}) begin
      failures++;
      $display("FAIL bin1 idx=%0d re=%0d im=%h sof=%b required idx 1 re 16 im ffF0 sof 0", index_o, data_out_r, data_out_i, sof_o);
    end
    tick();
    checks++;
    if ({index_o, data_out_r} !== {5'd2, 16'd8}) begin
      failures++;
      $display("FAIL bin2 idx=%0d re=%0d required idx 2 re 8", index_o, data_out_r);
    end
    repeat (29) tick();
    checks++;
    if ({valid_o, index_o, data_out_r} !== {1'b1, 5'd31, 16'd31}) begin
      failures++;
      $display("FAIL bin31 valid=%b idx=%0d re=%0d required 1/31/31", valid_o, index_o, data_out_r);
    end
    wait_drain(100);
  endtask

  task automatic test_back_to_back();
    int bubbles = 0;
    int sofs    = 0;
    int w       = 0;
    ready_i = 1'b1;
    fork
      begin
        for (int f = 1; f <= 3; f++) send_frame(f, 0);
      end
      begin
        @(negedge clk);
        while (!valid_o && w < 100) begin
          @(negedge clk);
          w++;
        end
        for (int i = 0; i < 96; i++) begin
          if (!valid_o) bubbles++;
          if (sof_o) sofs++;
          @(negedge clk);
        end
      end
    join
    checks++;
    if (bubbles != 0 || sofs != 3) begin
      failures++;
      $display("FAIL back_to_back bubbles=%0d sofs=%0d required 0 and 3", bubbles, sofs);
    end
    wait_drain(100);
    checks++;
    if (overflow_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_overflow overflow_o=%b required 0", overflow_o);
    end
  endtask

  task automatic test_gaps();
    int base = xfer_cnt;
    ready_i = 1'b1;
    for (int f = 4; f <= 5; f++) send_frame(f, 50);
    wait_drain(200);
    checks++;
    if (xfer_cnt - base != 64) begin
      failures++;
      $display("FAIL gaps_count outputs=%0d required 64", xfer_cnt - base);
    end
  endtask

  task automatic test_overflow();
    int base = xfer_cnt;
    ready_i = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          for (int k = 0; k < 32; k++) begin
            put(sval(10 + f, k), -sval(10 + f, k));
            if (f == 1 && k == 31) begin
              checks++;
              if (overflow_o !== 1'b0) begin
                failures++;
                $display("FAIL ovf_early overflow_o=%b required 0", overflow_o);
              end
            end
            if (f == 2 && k == 0) begin
              checks++;
              if (overflow_o !== 1'b1) begin
                failures++;
                $display("FAIL ovf_set overflow_o=%b required 1", overflow_o);
              end
            end
          end
          if (f < 2) push_frame(10 + f);
        end
      end
      begin
        repeat (70) tick();
        ready_i = 1'b1;
      end
    join
    wait_drain(200);
    repeat (40) tick();
    checks++;
    if (xfer_cnt - base != 64 || overflow_o !== 1'b1) begin
      failures++;
      $display("FAIL ovf_outputs outputs=%0d overflow_o=%b required 64 and 1", xfer_cnt - base, overflow_o);
    end
  endtask

  task automatic test_ready_toggle();
    logic        done = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] s_re, s_im;
    logic [4:0]  s_idx;
    int          n = 0;
    fork
      begin
        for (int f = 20; f <= 21; f++) send_frame(f, 20);
        done = 1'b1;
      end
      begin
        while (!(done && sb.size() == 0) && n < 1000) begin
          @(negedge clk);
          if (hold) begin
            checks++;
            if ({valid_o, data_out_r, data_out_i, index_o} !== {1'b1, s_re, s_im, s_idx}) begin
              failures++;
              $display("FAIL hold_stable valid=%b re=%h im=%h idx=%0d required 1 re=%h im=%h idx=%0d",
                       valid_o, data_out_r, data_out_i, index_o, s_re, s_im, s_idx);
            end
          end
          hold  = valid_o && !ready_i;
          s_re  = data_out_r;
          s_im  = data_out_i;
          s_idx = index_o;
          tick();
          ready_i = 1'($urandom_range(1));
          n++;
        end
      end
    join
    ready_i = 1'b1;
    wait_drain(100);
  endtask

  task automatic test_reset_mid();
    int w = 0;
    ready_i = 1'b1;
    for (int k = 0; k < 20; k++) put(sval(30, k), -sval(30, k));
    rst = 1'b1;
    #1;
    checks++;
    if ({valid_o, data_out_r, data_out_i, index_o, sof_o, overflow_o} !== 39'd0) begin
      failures++;
      $display("FAIL reset_in_input valid=%b re=%h idx=%0d ovf=%b required all zero", valid_o, data_out_r, index_o, overflow_o);
    end
    tick();
    rst = 1'b0;
    tick();
    send_frame(40, 0);
    tick();
    while (!(valid_o && index_o == 5'd10) && w < 100) begin
      tick();
      w++;
    end
    checks++;
    if (!(valid_o && index_o == 5'd10)) begin
      failures++;
      $display("FAIL reach_bin10 valid=%b idx=%0d required 1 and 10", valid_o, index_o);
    end
    rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if ({valid_o, data_out_r, data_out_i, index_o, sof_o} !== 38'd0) begin
      failures++;
      $display("FAIL reset_in_output valid=%b re=%h im=%h idx=%0d sof=%b required all zero",
               valid_o, data_out_r, data_out_i, index_o, sof_o);
    end
    tick();
    rst = 1'b0;
    tick();
    send_frame(41, 0);
    wait_drain(100);
  endtask

  initial begin
    rst       = 1'b1;
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    data_in_r = '0;
    data_in_i = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gaps();
    test_overflow();
    test_reset();
    test_ready_toggle();
    test_reset_mid();
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
